exp5_exibe_sequencia: RTL and testbench



---
 rtl/exp5_pkg.sv | 33 +++
 rtl/exp5_temporizador.sv | 38 +++
 rtl/exp5_exibe_sequencia.sv | 100 ++++++++++
 tb/tb_exp5_exibe_sequencia.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/exp5_pkg.sv
// Shared definitions for the memory-game playback datapath: state codes,
// one-hot move encoding and sizing helpers.
package exp5_pkg;

    localparam int ADDR_W_DEF = 4;

    localparam logic [2:0] ST_INICIAL = 3'd0;
    localparam logic [2:0] ST_PREPARA = 3'd1;
    localparam logic [2:0] ST_ACENDE  = 3'd2;
    localparam logic [2:0] ST_APAGA   = 3'd3;
    localparam logic [2:0] ST_PROXIMO = 3'd4;
    localparam logic [2:0] ST_FIM     = 3'd5;

    typedef enum logic [2:0] {
        INICIAL = ST_INICIAL,
        PREPARA = ST_PREPARA,
        ACENDE  = ST_ACENDE,
        APAGA   = ST_APAGA,
        PROXIMO = ST_PROXIMO,
        FIM     = ST_FIM
    } estado_t;

    localparam logic [3:0] MOVE_0 = 4'b0001;
    localparam logic [3:0] MOVE_1 = 4'b0010;
    localparam logic [3:0] MOVE_2 = 4'b0100;
    localparam logic [3:0] MOVE_3 = 4'b1000;

    // A one-cycle timer still needs a 1-bit counter.
    function automatic int tam_cont(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/exp5_temporizador.sv
// Up-counting interval timer; fim flags the last cycle of an M-cycle interval.
module exp5_temporizador
    import exp5_pkg::*;
#(
    parameter int M = 500
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = tam_cont(M);

    logic [W-1:0] cont_q;
    logic [W-1:0] cont_d;

    always_comb begin
        cont_d = cont_q;
        if (zera) begin
            cont_d = '0;
        end else if (conta) begin
            cont_d = cont_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign fim = (cont_q == W'(M - 1));

endmodule

// File: rtl/exp5_exibe_sequencia.sv
// Memory-game playback: shows stored moves 0..limite on the LEDs, each lit
// for T_ON cycles then dark for T_OFF cycles, and raises pronto when done.
module exp5_exibe_sequencia
    import exp5_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int T_ON   = 500,
    parameter int T_OFF  = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [3:0]        dado,
    output logic [ADDR_W-1:0] endereco,
    output logic [3:0]        leds,
    output logic              exibindo,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] limite_r_q, limite_r_d;
    logic              zera_on, conta_on, fim_on;
    logic              zera_off, conta_off, fim_off;

    exp5_temporizador #(.M(T_ON)) u_tmr_on (
        .clock (clock),
        .reset (reset),
        .zera  (zera_on),
        .conta (conta_on),
        .fim   (fim_on)
    );

    exp5_temporizador #(.M(T_OFF)) u_tmr_off (
        .clock (clock),
        .reset (reset),
        .zera  (zera_off),
        .conta (conta_off),
        .fim   (fim_off)
    );

    always_comb begin
        estado_d   = estado_q;
        end_d      = end_q;
        limite_r_d = limite_r_q;
        zera_on    = 1'b0;
        conta_on   = 1'b0;
        zera_off   = 1'b0;
        conta_off  = 1'b0;
        case (estado_q)
            INICIAL: if (iniciar) estado_d = PREPARA;
            PREPARA: begin
                end_d      = '0;
                limite_r_d = limite;
                zera_on    = 1'b1;
                zera_off   = 1'b1;
                estado_d   = ACENDE;
            end
            ACENDE: begin
                // Off-timer is held clear while lit so apaga starts from zero.
                conta_on = 1'b1;
                zera_off = 1'b1;
                if (fim_on) estado_d = APAGA;
            end
            APAGA: begin
                conta_off = 1'b1;
                if (fim_off) estado_d = (end_q == limite_r_q) ? FIM : PROXIMO;
            end
            PROXIMO: begin
                end_d    = end_q + 1'b1;
                zera_on  = 1'b1;
                estado_d = ACENDE;
            end
            FIM:     if (iniciar) estado_d = PREPARA;
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= INICIAL;
            end_q      <= '0;
            limite_r_q <= '0;
        end else begin
            estado_q   <= estado_d;
            end_q      <= end_d;
            limite_r_q <= limite_r_d;
        end
    end

    assign endereco  = end_q;
    assign leds      = (estado_q == ACENDE) ? dado : 4'b0000;
    assign exibindo  = (estado_q == PREPARA) || (estado_q == ACENDE) ||
                       (estado_q == APAGA)   || (estado_q == PROXIMO);
    assign pronto    = (estado_q == FIM);
    assign db_estado = estado_q;

endmodule

// File: tb/tb_exp5_exibe_sequencia.sv
// Directed bench for the playback controller with a lit-cycle scoreboard.
module tb_exp5_exibe_sequencia;
    import exp5_pkg::*;

    localparam int ADDR_W = 4;
    localparam int T_ON   = 3;
    localparam int T_OFF  = 2;

    typedef struct packed {
        logic [3:0]        leds;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              iniciar;
    logic [ADDR_W-1:0] limite;
    logic [3:0]        dado;
    logic [ADDR_W-1:0] endereco;
    logic [3:0]        leds;
    logic              exibindo;
    logic              pronto;
    logic [2:0]        db_estado;

    logic [3:0] mem [16];
    exp_t       sb [$];
    int         tests = 0;
    int         fails = 0;

    exp5_exibe_sequencia #(.ADDR_W(ADDR_W), .T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .exibindo  (exibindo),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    always_comb dado = mem[endereco];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every lit cycle must match the next scoreboard entry; dark cycles must be dark.
    always @(negedge clock) begin
        if (db_estado == ST_ACENDE) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(leds), 32'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("lit_leds", 32'(leds), 32'(e.leds));
                check("lit_addr", 32'(endereco), 32'(e.addr));
            end
        end else begin
            check("dark_leds", 32'(leds), 32'h0);
        end
    end

    task automatic push_exp(input int lim);
        for (int i = 0; i <= lim; i++)
            for (int t = 0; t < T_ON; t++)
                sb.push_back('{leds: mem[i], addr: ADDR_W'(i)});
    endtask

    // Pulses iniciar, then counts cycles from the sampling edge until pronto.
    task automatic play(input int lim, input int chg_at);
        int n;
        limite = ADDR_W'(lim);
        push_exp(lim);
        @(negedge clock);
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        iniciar = 1'b0;
        check("prepara_state", 32'(db_estado), 32'(ST_PREPARA));
        check("prepara_exib", 32'(exibindo), 32'd1);
        n = 0;
        while (!pronto && n < 400) begin
            @(posedge clock);
            #1;
            n++;
            if (n == chg_at) limite = ADDR_W'(1);
        end
        check("pronto_latency", 32'(n), 32'(1 + (lim + 1) * (T_ON + T_OFF) + lim));
        check("fim_state", 32'(db_estado), 32'(ST_FIM));
        check("fim_exib", 32'(exibindo), 32'd0);
        check("fim_addr", 32'(endereco), 32'(lim));
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        logic [3:0] moves [4];
        moves[0] = MOVE_0; moves[1] = MOVE_1; moves[2] = MOVE_2; moves[3] = MOVE_3;
        for (int i = 0; i < 16; i++) mem[i] = moves[(i * 3 + 1) % 4];

        reset = 1'b1; iniciar = 1'b0; limite = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_exib", 32'(exibindo), 32'd0);
        check("rst_addr", 32'(endereco), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("idle_state", 32'(db_estado), 32'(ST_INICIAL));
        check("idle_exib", 32'(exibindo), 32'd0);

        // Single entry
        mem[0] = 4'b0010;
        play(0, -1);

        // Four entries, one code each
        mem[0] = MOVE_0; mem[1] = MOVE_1; mem[2] = MOVE_2; mem[3] = MOVE_3;
        play(3, -1);

        // limite changed during acende of entry 0 must be ignored
        play(3, 2);

        // Reset during apaga of entry 2
        limite = ADDR_W'(3);
        push_exp(3);
        @(negedge clock);
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        iniciar = 1'b0;
        n = 0;
        while (!(db_estado == ST_APAGA && endereco == 2) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("reach_apaga2", 32'(db_estado), 32'(ST_APAGA));
        reset = 1'b1;
        #1;
        check("rst_mid_exib", 32'(exibindo), 32'd0);
        check("rst_mid_leds", 32'(leds), 32'h0);
        check("rst_mid_state", 32'(db_estado), 32'(ST_INICIAL));
        check("rst_mid_addr", 32'(endereco), 32'd0);
        check("rst_mid_left", 32'(sb.size()), 32'(T_ON));
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = moves[(i * 3 + 1) % 4];
        play(2, -1);

        // Full address range, then restart straight from fim
        play(15, -1);
        check("fim_before_restart", 32'(db_estado), 32'(ST_FIM));
        play(0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
